// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block.
// Defaults here seed the top-level parameters.
package stream_demux_pkg;

    localparam int unsigned DEF_BIT_WIDTH   = 8;
    localparam int unsigned DEF_NUM_VECTORS = 4;
    localparam int unsigned DEF_DEPTH       = 4;

    localparam int unsigned SEL_W = $clog2(DEF_NUM_VECTORS);
    localparam int unsigned PTR_W = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Wide enough for any supported channel count; callers truncate to NUM_VECTORS.
    localparam int unsigned MAX_VECTORS = 32;

    function automatic logic [MAX_VECTORS-1:0] onehot_mask(input int unsigned sel,
                                                           input logic        bcast);
        logic [MAX_VECTORS-1:0] m;
        m = bcast ? '1 : (MAX_VECTORS'(1) << sel);
        return m;
    endfunction

endpackage

// File: rtl/stream_demux_fifo.sv
// Single-channel synchronous FIFO used once per output channel of stream_demux.
// Storage is cleared on reset so the head output is never X.
module demux_fifo #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [BIT_WIDTH-1:0]     wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [BIT_WIDTH-1:0]     head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign head = mem[rd_ptr];

    a_count_range: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(rd_en && count == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && count == CW'(DEPTH)));

endmodule

// File: rtl/stream_demux.sv
// Buffered valid/ready demux: routes or broadcasts one input stream into
// per-channel FIFOs so one stalled consumer does not block the others.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int unsigned NUM_VECTORS = DEF_NUM_VECTORS,
    parameter int unsigned DEPTH       = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIT_WIDTH-1:0]            in_data,
    input  logic [$clog2(NUM_VECTORS)-1:0]  in_sel,
    input  logic                            in_bcast,
    output logic [NUM_VECTORS-1:0]          out_valid,
    input  logic [NUM_VECTORS-1:0]          out_ready,
    output logic [BIT_WIDTH-1:0]            out_data  [NUM_VECTORS],
    output logic [$clog2(DEPTH):0]          out_count [NUM_VECTORS]
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [NUM_VECTORS-1:0] mask;
    logic [NUM_VECTORS-1:0] room;
    logic [NUM_VECTORS-1:0] wr_en;
    logic                   push;

    // Readiness uses registered occupancy only, so out_ready never reaches in_ready.
    always_comb begin
        mask = NUM_VECTORS'(onehot_mask(32'(in_sel), in_bcast));
        for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
            room[i] = out_count[i] < CW'(DEPTH);
        end
        in_ready = &(room | ~mask);
        push     = in_valid & in_ready;
        wr_en    = mask & {NUM_VECTORS{push}};
    end

    for (genvar i = 0; i < NUM_VECTORS; i++) begin : g_ch
        demux_fifo #(
            .BIT_WIDTH (BIT_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .wr_en   (wr_en[i]),
            .rd_en   (out_valid[i] & out_ready[i]),
            .wr_data (in_data),
            .count   (out_count[i]),
            .head    (out_data[i])
        );

        assign out_valid[i] = (out_count[i] != '0);
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_stream_demux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int SW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, in_bcast;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_sel;
    logic [N-1:0]  out_valid, out_ready;
    logic [W-1:0]  out_data  [N];
    logic [CW-1:0] out_count [N];

    int vectors = 0;
    int errors  = 0;

    typedef logic [W-1:0] dq_t[$];
    dq_t q [N];

    always #5 clk = ~clk;

    stream_demux #(.BIT_WIDTH(W), .NUM_VECTORS(N), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    function automatic bit model_ready(input logic [SW-1:0] sel, input logic bc);
        for (int i = 0; i < N; i++)
            if ((bc || int'(sel) == i) && q[i].size() >= D) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock; the model applies the rules to the pre-edge inputs.
    task automatic tick();
        bit         acc;
        bit [N-1:0] tmask, pop;
        tmask = in_bcast ? '1 : (N'(1) << in_sel);
        acc   = in_valid && model_ready(in_sel, in_bcast);
        for (int i = 0; i < N; i++) pop[i] = out_ready[i] && q[i].size() > 0;
        @(posedge clk);
        if (reset || flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pop[i]) void'(q[i].pop_front());
                if (acc && tmask[i]) q[i].push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_bcast = 0; in_sel = '0; in_data = '0; out_ready = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (out_valid[i] !== 1'b0 || out_count[i] !== '0 || out_data[i] !== '0) begin
                errors++;
                $display("FAIL reset ch%0d: valid=%b count=%0d data=%h, want 0/0/00",
                         i, out_valid[i], out_count[i], out_data[i]);
            end
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_routing();
        idle();
        in_valid = 1; in_data = 8'hA1; in_sel = 2;
        tick();
        idle();
        vectors++;
        if (out_valid !== 4'b0100) begin
            errors++; $display("FAIL route_valid: got %b want 0100", out_valid);
        end
        vectors++;
        if (out_data[2] !== 8'hA1 || out_count[2] !== 3'd1) begin
            errors++; $display("FAIL route_data: data=%h count=%0d want a1/1", out_data[2], out_count[2]);
        end
        out_ready = 4'b0100;
        tick();
        idle();
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL route_pop: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d [5];
        idle();
        for (int k = 0; k < 5; k++) begin
            d[k] = W'($urandom);
            in_valid = 1; in_sel = 1; in_data = d[k];
            #1;
            vectors++;
            if (in_ready !== (k < 4)) begin
                errors++; $display("FAIL bp_accept%0d: in_ready=%b want %b", k, in_ready, k < 4);
            end
            tick();
        end
        idle();
        vectors++;
        if (out_count[1] !== 3'd4) begin
            errors++; $display("FAIL bp_count: got %0d want 4", out_count[1]);
        end
        in_sel = 1; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_sel1: got %b want 0", in_ready);
        end
        in_sel = 0; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_sel0: got %b want 1", in_ready);
        end
        out_ready[1] = 1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== d[k]) begin
                errors++; $display("FAIL bp_drain%0d: valid=%b data=%h want 1/%h",
                                   k, out_valid[1], out_data[1], d[k]);
            end
            tick();
        end
        idle();
        vectors++;
        if (out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL bp_empty: valid=%b want 0", out_valid[1]);
        end
    endtask

    task automatic test_broadcast();
        idle();
        in_valid = 1; in_sel = 0; in_data = 8'h11; tick();
        for (int k = 0; k < 4; k++) begin
            in_sel = 3; in_data = W'(8'h30 + k); tick();
        end
        idle();
        in_valid = 1; in_bcast = 1; in_data = 8'h5C; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bcast_blocked: in_ready=%b want 0", in_ready);
        end
        tick();
        idle();
        vectors++;
        if (out_count[0] !== 3'd1 || out_count[1] !== 3'd0 || out_count[2] !== 3'd0 || out_count[3] !== 3'd4) begin
            errors++; $display("FAIL bcast_nowrite: counts=%0d,%0d,%0d,%0d want 1,0,0,4",
                               out_count[0], out_count[1], out_count[2], out_count[3]);
        end
        out_ready = 4'b1000; tick(); idle();
        in_valid = 1; in_bcast = 1; in_data = 8'h5C; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bcast_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        idle();
        vectors++;
        if (out_count[0] !== 3'd2 || out_count[1] !== 3'd1 || out_count[2] !== 3'd1 || out_count[3] !== 3'd4) begin
            errors++; $display("FAIL bcast_counts: counts=%0d,%0d,%0d,%0d want 2,1,1,4",
                               out_count[0], out_count[1], out_count[2], out_count[3]);
        end
        out_ready = '1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() > 0) begin
                    vectors++;
                    if (out_valid[i] !== 1'b1 || out_data[i] !== q[i][0]) begin
                        errors++; $display("FAIL bcast_drain ch%0d: valid=%b data=%h want 1/%h",
                                           i, out_valid[i], out_data[i], q[i][0]);
                    end
                end
            end
            tick();
        end
        idle();
        vectors++;
        if (out_valid !== '0) begin
            errors++; $display("FAIL bcast_empty: valid=%b want 0000", out_valid);
        end
    endtask

    task automatic test_concurrent();
        logic [W-1:0] s [12];
        idle();
        for (int k = 0; k < 12; k++) s[k] = W'($urandom);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_sel = 0; in_data = s[k]; tick();
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1; in_sel = 0; in_data = s[k+2]; out_ready = 4'b0001; #1;
            vectors++;
            if (out_count[0] !== 3'd2 || out_data[0] !== s[k] || in_ready !== 1'b1) begin
                errors++; $display("FAIL conc%0d: count=%0d data=%h ready=%b want 2/%h/1",
                                   k, out_count[0], out_data[0], in_ready, s[k]);
            end
            tick();
        end
        idle();
        out_ready = 4'b0001;
        for (int k = 10; k < 12; k++) begin
            vectors++;
            if (out_data[0] !== s[k]) begin
                errors++; $display("FAIL conc_tail%0d: data=%h want %h", k, out_data[0], s[k]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1; in_sel = SW'(k % N); in_data = W'($urandom); tick();
        end
        flush = 1; in_valid = 1; in_sel = 1; in_data = 8'hEE; out_ready = '1;
        tick();
        idle();
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (out_valid[i] !== 1'b0 || out_count[i] !== '0) begin
                errors++; $display("FAIL flush ch%0d: valid=%b count=%0d want 0/0",
                                   i, out_valid[i], out_count[i]);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_bcast  = ($urandom_range(0, 7) == 0);
            in_sel    = SW'($urandom);
            in_data   = W'($urandom);
            out_ready = N'($urandom) & N'($urandom);
            #1;
            vectors++;
            if (in_ready !== model_ready(in_sel, in_bcast)) begin
                errors++; $display("FAIL rand%0d in_ready: got %b want %b",
                                   c, in_ready, model_ready(in_sel, in_bcast));
            end
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (out_count[i] !== CW'(q[i].size()) || out_valid[i] !== (q[i].size() > 0) ||
                    (q[i].size() > 0 && out_data[i] !== q[i][0])) begin
                    errors++; $display("FAIL rand%0d ch%0d: count=%0d valid=%b data=%h want count=%0d",
                                       c, i, out_count[i], out_valid[i], out_data[i], q[i].size());
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        test_random(15);
        in_valid = 1; in_sel = 2; in_data = 8'h77; out_ready = '1; reset = 1;
        tick();
        reset = 0; idle(); #1;
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (out_valid[i] !== 1'b0 || out_count[i] !== '0 || out_data[i] !== '0) begin
                errors++; $display("FAIL midreset ch%0d: valid=%b count=%0d data=%h want 0/0/00",
                                   i, out_valid[i], out_count[i], out_data[i]);
            end
        end
        in_bcast = 1; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got %b want 1", in_ready);
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_routing();
        test_backpressure();
        test_broadcast();
        test_concurrent();
        test_flush();
        test_random(400);
        test_reset_midstream();
        test_random(100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
